// File: rtl/cpu_datapath.sv
// cpu_datapath
//   Register/ALU datapath driven by a 32-bit microinstruction word (bit n = Cn).
//   Holds MAR, MBR, PC, IR, BR, ACC and the ALU flags, and drives the word
//   memory port of a 256 x DATA_W main memory.
//
// Ports
//   clk             in   clock
//   rst             in   synchronous active-high reset
//   Control_Signals in   microinstruction (C0-C2, C22-C31 unused)
//   IR_out          out  opcode register
//   ALUflags        out  {ZF, CF, OF, SF}, registered
//   mem_addr        out  MAR
//   mem_rdata       in   memory read data (combinational on mem_addr)
//   mem_wdata       out  MBR
//   mem_we          out  C11, gated low during reset
//   pc_out          out  PC (debug)
//   acc_out         out  ACC (debug)
module cpu_datapath #(
  parameter logic [7:0]  PC_RESET = 8'h00,
  parameter int unsigned DATA_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       Control_Signals,
  output logic [7:0]        IR_out,
  output logic [3:0]        ALUflags,
  output logic [7:0]        mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic [7:0]        pc_out,
  output logic [DATA_W-1:0] acc_out
);

  logic [7:0]        r_mar;
  logic [DATA_W-1:0] r_mbr;
  logic [7:0]        r_pc;
  logic [7:0]        r_ir;
  logic [DATA_W-1:0] r_br;
  logic [DATA_W-1:0] r_acc;
  logic [3:0]        r_flags;

  logic                      w_unused;
  logic [DATA_W:0]           w_sum;
  logic [DATA_W:0]           w_diff;
  logic signed [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]         w_quot;
  logic [DATA_W:0]           w_shl;
  logic [DATA_W:0]           w_shr;
  logic                      w_shamt_big;

  logic              w_alu_en;
  logic [DATA_W-1:0] w_res;
  logic              w_cf;
  logic              w_of;
  logic              w_zf;
  logic              w_sf;

  assign w_unused = &{Control_Signals[31:22], Control_Signals[2:0]};

  assign w_sum  = {1'b0, r_acc} + {1'b0, r_br};
  assign w_diff = {1'b0, r_acc} - {1'b0, r_br};
  assign w_prod = $signed(r_acc) * $signed(r_br);
  assign w_quot = $signed(r_acc) / $signed(r_br);

  // One extra bit beside the data catches the last bit shifted out.
  assign w_shl       = {1'b0, r_acc} << r_br[3:0];
  assign w_shr       = {r_acc, 1'b0} >> r_br[3:0];
  assign w_shamt_big = |r_br[DATA_W-1:4];

  always_comb begin
    w_alu_en = 1'b0;
    w_res    = r_acc;
    w_cf     = 1'b0;
    w_of     = 1'b0;
    if (Control_Signals[8]) begin
      w_alu_en = 1'b1;
      w_res    = '0;
    end else if (Control_Signals[9]) begin
      w_alu_en = 1'b1;
      w_res    = w_sum[DATA_W-1:0];
      w_cf     = w_sum[DATA_W];
      w_of     = (r_acc[DATA_W-1] == r_br[DATA_W-1]) &&
                 (w_sum[DATA_W-1] != r_acc[DATA_W-1]);
    end else if (Control_Signals[13]) begin
      w_alu_en = 1'b1;
      w_res    = w_diff[DATA_W-1:0];
      w_cf     = w_diff[DATA_W];
      w_of     = (r_acc[DATA_W-1] != r_br[DATA_W-1]) &&
                 (w_diff[DATA_W-1] != r_acc[DATA_W-1]);
    end else if (Control_Signals[15]) begin
      w_alu_en = 1'b1;
      w_res    = w_prod[DATA_W-1:0];
      w_of     = (w_prod[2*DATA_W-1:DATA_W] != {DATA_W{w_prod[DATA_W-1]}});
    end else if (Control_Signals[16]) begin
      w_alu_en = 1'b1;
      if (r_br == '0) begin
        w_res = r_acc;
        w_of  = 1'b1;
      end else if (r_acc == {1'b1, {(DATA_W-1){1'b0}}} && r_br == '1) begin
        // Most-negative / -1 overflows; result saturates to the dividend.
        w_res = r_acc;
        w_of  = 1'b1;
      end else begin
        w_res = w_quot;
      end
    end else if (Control_Signals[17]) begin
      w_alu_en = 1'b1;
      // Amounts of 16 or more clear the result; carry reported as 0.
      w_res    = w_shamt_big ? '0 : w_shl[DATA_W-1:0];
      w_cf     = w_shamt_big ? 1'b0 : w_shl[DATA_W];
    end else if (Control_Signals[18]) begin
      w_alu_en = 1'b1;
      w_res    = w_shamt_big ? '0 : w_shr[DATA_W:1];
      w_cf     = w_shamt_big ? 1'b0 : w_shr[0];
    end else if (Control_Signals[19]) begin
      w_alu_en = 1'b1;
      w_res    = r_acc & r_br;
    end else if (Control_Signals[20]) begin
      w_alu_en = 1'b1;
      w_res    = r_acc | r_br;
    end else if (Control_Signals[21]) begin
      w_alu_en = 1'b1;
      w_res    = ~r_br;
    end
    w_zf = (w_res == '0);
    w_sf = w_res[DATA_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mar   <= PC_RESET;
      r_pc    <= PC_RESET;
      r_mbr   <= '0;
      r_ir    <= '0;
      r_br    <= '0;
      r_acc   <= '0;
      r_flags <= 4'b1000;
    end else begin
      if (Control_Signals[12])      r_mbr <= r_acc;
      else if (Control_Signals[3])  r_mbr <= mem_rdata;

      if (Control_Signals[4])       r_ir <= r_mbr[15:8];

      if (Control_Signals[10])      r_mar <= r_pc;
      else if (Control_Signals[5])  r_mar <= r_mbr[7:0];

      if (Control_Signals[14])      r_pc <= r_mbr[7:0];
      else if (Control_Signals[6])  r_pc <= r_pc + 8'd1;

      if (Control_Signals[7])       r_br <= r_mbr;

      if (w_alu_en) begin
        r_acc   <= w_res;
        r_flags <= {w_zf, w_cf, w_of, w_sf};
      end
    end
  end

  assign IR_out    = r_ir;
  assign ALUflags  = r_flags;
  assign mem_addr  = r_mar;
  assign mem_wdata = r_mbr;
  assign mem_we    = Control_Signals[11] & ~rst;
  assign pc_out    = r_pc;
  assign acc_out   = r_acc;

endmodule

// File: tb/tb_cpu_datapath.sv
module tb_cpu_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cs;
  logic [7:0]  ir_out;
  logic [3:0]  flags;
  logic [7:0]  mem_addr;
  logic [15:0] mem_rdata;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [7:0]  pc_out;
  logic [15:0] acc_out;

  logic [15:0] mem [256];

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] C3  = 32'b1 << 3;
  localparam logic [31:0] C4  = 32'b1 << 4;
  localparam logic [31:0] C5  = 32'b1 << 5;
  localparam logic [31:0] C6  = 32'b1 << 6;
  localparam logic [31:0] C7  = 32'b1 << 7;
  localparam logic [31:0] C8  = 32'b1 << 8;
  localparam logic [31:0] C9  = 32'b1 << 9;
  localparam logic [31:0] C10 = 32'b1 << 10;
  localparam logic [31:0] C11 = 32'b1 << 11;
  localparam logic [31:0] C12 = 32'b1 << 12;
  localparam logic [31:0] C13 = 32'b1 << 13;
  localparam logic [31:0] C14 = 32'b1 << 14;
  localparam logic [31:0] C15 = 32'b1 << 15;
  localparam logic [31:0] C16 = 32'b1 << 16;
  localparam logic [31:0] C17 = 32'b1 << 17;
  localparam logic [31:0] C18 = 32'b1 << 18;
  localparam logic [31:0] C19 = 32'b1 << 19;
  localparam logic [31:0] C20 = 32'b1 << 20;
  localparam logic [31:0] C21 = 32'b1 << 21;

  cpu_datapath #(.PC_RESET(8'h00), .DATA_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .Control_Signals (cs),
    .IR_out          (ir_out),
    .ALUflags        (flags),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .mem_wdata       (mem_wdata),
    .mem_we          (mem_we),
    .pc_out          (pc_out),
    .acc_out         (acc_out)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  typedef struct {
    logic [15:0] acc;
    logic [15:0] br;
    logic [31:0] op;
    logic [15:0] exp_acc;
    logic [3:0]  exp_fl;
    logic [3:0]  fl_mask;
  } vec_t;

  localparam int NV = 20;
  vec_t vt [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Apply one microinstruction from a negedge, return at the next negedge.
  task automatic step(input logic [31:0] c);
    cs = c;
    @(posedge clk);
    @(negedge clk);
    cs = '0;
  endtask

  task automatic set_mbr(input logic [15:0] v);
    mem[mem_addr] <= v;
    #1;
    step(C3);
  endtask

  task automatic set_acc_br(input logic [15:0] a, input logic [15:0] b);
    set_mbr(a);
    step(C7 | C8);
    step(C9);
    set_mbr(b);
    step(C7);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
    rst = 1'b1;
    cs  = 32'hFFFF_FFFF;

    // {acc, br, op, expected acc, expected {ZF,CF,OF,SF}, flag mask}
    vt[0]  = '{16'h7FFF, 16'h0001, C9,  16'h8000, 4'b0011, 4'hF};
    vt[1]  = '{16'h0000, 16'h0001, C13, 16'hFFFF, 4'b0101, 4'hF};
    vt[2]  = '{16'h0100, 16'h0100, C15, 16'h0000, 4'b1010, 4'hF};
    vt[3]  = '{16'hFFF9, 16'h0002, C16, 16'hFFFD, 4'b0001, 4'hF};
    vt[4]  = '{16'h1234, 16'h0000, C16, 16'h1234, 4'b0010, 4'hF};
    vt[5]  = '{16'h8000, 16'hFFFF, C16, 16'h8000, 4'b0011, 4'hF};
    vt[6]  = '{16'h8001, 16'h0001, C17, 16'h0002, 4'b0100, 4'hF};
    vt[7]  = '{16'hFFFF, 16'h0010, C18, 16'h0000, 4'b1000, 4'b1011};
    vt[8]  = '{16'h8001, 16'h0001, C18, 16'h4000, 4'b0100, 4'hF};
    vt[9]  = '{16'h5555, 16'h0000, C17, 16'h5555, 4'b0000, 4'hF};
    vt[10] = '{16'hF0F0, 16'h3C3C, C19, 16'h3030, 4'b0000, 4'hF};
    vt[11] = '{16'hF0F0, 16'h0F0F, C20, 16'hFFFF, 4'b0001, 4'hF};
    vt[12] = '{16'h1234, 16'hFFFF, C21, 16'h0000, 4'b1000, 4'hF};
    vt[13] = '{16'hFFFF, 16'h0001, C9,  16'h0000, 4'b1100, 4'hF};
    vt[14] = '{16'h8000, 16'h0001, C13, 16'h7FFF, 4'b0010, 4'hF};
    vt[15] = '{16'hC000, 16'h0002, C15, 16'h8000, 4'b0001, 4'hF};
    vt[16] = '{16'h0007, 16'hFFFE, C16, 16'hFFFD, 4'b0001, 4'hF};
    vt[17] = '{16'h0005, 16'h0003, C9 | C13,  16'h0008, 4'b0000, 4'hF};
    vt[18] = '{16'h0005, 16'h0003, C13 | C19, 16'h0002, 4'b0000, 4'hF};
    vt[19] = '{16'h0005, 16'h0003, C8 | C9,   16'h0000, 4'b1000, 4'hF};

    // Reset with every control bit high.
    @(negedge clk);
    chk("rst_we", {31'b0, mem_we}, 32'd0);
    chk("rst_pc", {24'b0, pc_out}, 32'h00);
    chk("rst_mar", {24'b0, mem_addr}, 32'h00);
    chk("rst_mbr", {16'b0, mem_wdata}, 32'h0);
    chk("rst_acc", {16'b0, acc_out}, 32'h0);
    chk("rst_ir", {24'b0, ir_out}, 32'h0);
    chk("rst_flags", {28'b0, flags}, 32'b1000);
    @(negedge clk);
    chk("rst_we2", {31'b0, mem_we}, 32'd0);
    rst = 1'b0;
    cs  = '0;

    // Fetch followed by LOAD.
    mem[0] <= 16'h0205;
    mem[5] <= 16'h0007;
    #1;
    step(C3);
    step(C4);
    step(C5 | C6);
    step(C3);
    step(C7 | C8);
    step(C9);
    chk("load_ir", {24'b0, ir_out}, 32'h02);
    chk("load_mar", {24'b0, mem_addr}, 32'h05);
    chk("load_pc", {24'b0, pc_out}, 32'h01);
    chk("load_acc", {16'b0, acc_out}, 32'h0007);
    chk("load_flags", {28'b0, flags}, 32'b0000);

    // ALU vectors.
    for (int i = 0; i < NV; i++) begin
      set_acc_br(vt[i].acc, vt[i].br);
      step(vt[i].op);
      chk($sformatf("vec%0d_acc", i), {16'b0, acc_out}, {16'b0, vt[i].exp_acc});
      chk($sformatf("vec%0d_flags", i), {28'b0, flags & vt[i].fl_mask},
          {28'b0, vt[i].exp_fl & vt[i].fl_mask});
    end

    // STORE: MAR=10, ACC=1234, then C12 and C11.
    set_mbr(16'h0010);
    step(C5);
    set_acc_br(16'h1234, 16'h0000);
    step(C12);
    mem[8'h10] <= 16'h0000;
    cs = C11;
    #1;
    chk("st_we", {31'b0, mem_we}, 32'd1);
    chk("st_addr", {24'b0, mem_addr}, 32'h10);
    chk("st_wdata", {16'b0, mem_wdata}, 32'h1234);
    @(posedge clk);
    @(negedge clk);
    cs = '0;
    #1;
    chk("st_we_off", {31'b0, mem_we}, 32'd0);
    chk("st_mem", {16'b0, mem[8'h10]}, 32'h1234);

    // PC load has priority over increment.
    set_mbr(16'h00AB);
    step(C14 | C6);
    chk("pc_load", {24'b0, pc_out}, 32'hAB);

    // PC wrap.
    set_mbr(16'h00FF);
    step(C14);
    step(C6);
    chk("pc_wrap", {24'b0, pc_out}, 32'h00);

    // MAR from PC wins over MAR from MBR.
    set_mbr(16'h0042);
    step(C14);
    set_mbr(16'h0033);
    step(C5 | C10);
    chk("mar_prio", {24'b0, mem_addr}, 32'h42);

    // BR load alongside ADD: ADD uses the old BR.
    set_acc_br(16'h0005, 16'h0003);
    set_mbr(16'h0100);
    step(C7 | C9);
    chk("oldbr_1", {16'b0, acc_out}, 32'h0008);
    step(C9);
    chk("oldbr_2", {16'b0, acc_out}, 32'h0108);

    // Flags hold across non-ALU microinstructions.
    set_acc_br(16'h0000, 16'h0001);
    step(C13);
    step(C3 | C4 | C7);
    chk("hold_flags", {28'b0, flags}, 32'b0101);
    chk("hold_acc", {16'b0, acc_out}, 32'hFFFF);

    // Reset mid-instruction overrides all control bits.
    rst = 1'b1;
    cs  = 32'hFFFF_FFFF;
    #1;
    chk("mrst_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("mrst_pc", {24'b0, pc_out}, 32'h00);
    chk("mrst_acc", {16'b0, acc_out}, 32'h0);
    chk("mrst_flags", {28'b0, flags}, 32'b1000);
    rst = 1'b0;
    cs  = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected done");
    $fatal(1);
  end

endmodule

// File: doc/cpu_datapath.md
Name: cpu_datapath

Overview:
- Register/ALU datapath that executes the 32-bit microinstruction word issued each cycle by the microprogrammed control unit.
- Feeds back the opcode (IR_out) and the ALU status flags (ALUflags) that the control unit uses for dispatch and conditional branching.
- Owns MAR, MBR, PC, IR, BR and ACC, plus the word-memory port.
- Sits between the control unit and the 256x16 main memory.

Parameters:
- PC_RESET, 8'h00, reset value of PC and MAR (first fetch address).
- DATA_W, 16, width of MBR/BR/ACC and memory words; fixed at 16, instruction = {opcode[15:8], address[7:0]}.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- Control_Signals  in  32  registered microinstruction from the control unit; bit n = Cn.
- IR_out  out  8  opcode register, to the control unit.
- ALUflags  out  4  {ZF, CF, OF, SF}, registered.
- mem_addr  out  8  equals MAR.
- mem_rdata  in  16  memory read data, combinational w.r.t. mem_addr.
- mem_wdata  out  16  equals MBR.
- mem_we  out  1  equals C11; forced 0 while rst=1.
- pc_out  out  8  PC, for debug.
- acc_out  out  16  ACC, for debug.

Behaviour:
- Reset (rst=1 at a posedge): PC=MAR=PC_RESET; MBR=BR=ACC=0; IR=0; flags=4'b1000 (ZF=1).
- Control bits:
  - C0–C2 and C22–C31 are ignored.
  - Every other bit acts at the posedge on which it is sampled high.
  - All register updates are simultaneous; every source reads its pre-edge value.
- MBR: C12 -> ACC; else C3 -> mem_rdata. C12 has priority over C3.
- IR: C4 -> MBR[15:8].
- MAR: C10 -> PC; else C5 -> MBR[7:0]. C10 has priority over C5.
- PC: C14 -> MBR[7:0]; else C6 -> PC+1, wrapping 8'hFF -> 8'h00.
- BR: C7 -> MBR. With C7 and an ALU op in the same cycle, the ALU uses the old BR.
- Memory write: mem_we=C11 with mem_wdata=MBR (pre-edge). C11 together with C12 writes the old MBR.
- ACC ops: at most one takes effect. Priority order: C8 > C9 > C13 > C15 > C16 > C17 > C18 > C19 > C20 > C21.
  - C8: ACC=0; flags ZF=1, CF=OF=SF=0.
  - C9 ADD: 17-bit sum; CF=carry out; OF=signed overflow.
  - C13 SUB: ACC-BR; CF=borrow (ACC<BR unsigned); OF=signed overflow.
  - C15 MPY: signed 16x16 multiply, ACC = product[15:0]; OF=1 if the product is not representable in signed 16 bits; CF=0.
  - C16 DIV: signed divide, quotient truncated toward zero.
    - BR=0: ACC unchanged, OF=1, CF=0.
    - 16'h8000 / 16'hFFFF: ACC=16'h8000, OF=1.
  - C17 SHL / C18 SHR: logical shifts.
    - Shift amount = BR[3:0]; if BR[15:4]!=0 the result is 0.
    - CF = last bit shifted out; CF=0 when the amount is 0. OF=0.
  - C19 AND, C20 OR, C21 NOT (ACC=~BR): CF=OF=0.
- Flags:
  - SF=result[15], ZF=(result==0) for every ALU op. For a DIV by zero they reflect the unchanged ACC.
  - Flags change only on C8/C9/C13/C15–C21 and otherwise hold.
- All outputs are registers or direct wires from registers. The only combinational output is mem_we, decoded from Control_Signals.
- Reset mid-instruction: rst overrides all control bits in the same cycle. No write occurs on that cycle.

Test Plan:
- Reset: assert rst with Control_Signals=32'hFFFFFFFF -> next cycle all registers at reset values, ALUflags=4'b1000, mem_we=0 throughout.
- Fetch/LOAD: mem[0]=16'h0205, mem[5]=16'h0007; drive the sequence C3; C4; C5|C6; C3; C7|C8; C9 -> IR_out=8'h02, MAR=5, PC=1, ACC=7, ALUflags=4'b0000.
- STORE: ACC=16'h1234, MAR=8'h10; drive C12 then C11 -> one cycle with mem_we=1, mem_addr=8'h10, mem_wdata=16'h1234.
- ADD/SUB flags:
  - ACC=16'h7FFF + BR=1 -> ACC=16'h8000, OF=1, SF=1, CF=0.
  - ACC=0 - BR=1 -> ACC=16'hFFFF, CF=1, SF=1.
- MPY/DIV:
  - 16'h0100 * 16'h0100 -> ACC=0, OF=1, ZF=1.
  - ACC=16'hFFF9 / BR=2 -> ACC=16'hFFFD.
  - DIV by BR=0 -> ACC unchanged, OF=1.
- Shift/priority/PC:
  - ACC=16'h8001 SHL by BR=1 -> ACC=2, CF=1.
  - BR=16'h0010 SHR -> ACC=0, ZF=1.
  - C14|C6 with MBR=16'h00AB -> PC=8'hAB.
  - PC=8'hFF with C6 -> PC=0.
  - C5|C10 together -> MAR=PC.
